// File: rtl/gmii_pkg.sv
// Shared constants and state encoding for the GMII stream receiver/transmitter.
package gmii_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_DST,
    ST_SRC,
    ST_ETYPE,
    ST_HDR,
    ST_VID,
    ST_AUD,
    ST_TAIL,
    ST_DROP
  } gmii_state_e;

  localparam logic [7:0] PREAMBLE   = 8'h55;
  localparam logic [7:0] SFD        = 8'hD5;
  localparam logic [7:0] KIND_VIDEO = 8'h00;
  localparam logic [7:0] KIND_AUDIO = 8'h01;

  localparam int HDR_LEN = 6;

  // Non-reflected register form: a good frame including its FCS leaves CRC_RESIDUE.
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide combinational CRC-32 step; data bits enter LSB first (Ethernet wire order).
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c_v;

  always_comb begin
    c_v = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c_v[31] ^ data_i[i]) begin
        c_v = {c_v[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        c_v = {c_v[30:0], 1'b0};
      end
    end
    crc_o = c_v;
  end

endmodule

// File: rtl/gmii_rx.sv
// GMII stream receiver: parses MAC/stream headers and writes video words / audio samples.
// Optional FCS residue check is enabled with the GMII_RX_FCS_CHECK_EN macro.
module gmii_rx
  import gmii_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR   = 48'h00_23_45_67_89_01,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter logic [10:0] MAX_VWORDS = 11'd640
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic [47:0] vdin,
  output logic        v_wr_en,
  input  logic        v_full,
  output logic [10:0] vline,
  output logic        line_start,
  output logic [11:0] adin,
  output logic        a_wr_en,
  input  logic        a_full,
  output logic        frame_drop,
  output logic        frame_err
);

  gmii_state_e state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        mac_ok_q, mac_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic [39:0] shift_q, shift_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic [47:0] vdin_q, vdin_d;
  logic        v_wr_en_q, v_wr_en_d;
  logic [10:0] vline_q, vline_d;
  logic        line_start_q, line_start_d;
  logic [11:0] adin_q, adin_d;
  logic        a_wr_en_q, a_wr_en_d;
  logic        frame_drop_q, frame_drop_d;

  logic [47:0] mac_sh;
  logic        dst_hit, bc_hit, bcnt_last;
  logic [15:0] cnt_w;
  logic        is_vid, is_aud, hdr_bad;

  // Header fields sit in the shift register once the 6th header byte is on rxd.
  assign mac_sh    = MAC_ADDR << {bcnt_q, 3'b000};
  assign dst_hit   = mac_ok_q && (rxd == mac_sh[47:40]);
  assign bc_hit    = bc_ok_q && (rxd == 8'hFF);
  assign bcnt_last = (bcnt_q == 3'(HDR_LEN - 1));
  assign cnt_w     = {shift_q[7:0], rxd};
  assign is_vid    = (shift_q[31:24] == KIND_VIDEO);
  assign is_aud    = (shift_q[31:24] == KIND_AUDIO);
  assign hdr_bad   = (shift_q[32] != id) || !(is_vid || is_aud) || (cnt_w == 16'd0) ||
                     (cnt_w[15:11] != 5'd0) || (is_vid && (cnt_w[10:0] > MAX_VWORDS));

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    mac_ok_d     = mac_ok_q;
    bc_ok_d      = bc_ok_q;
    shift_d      = rx_dv ? {shift_q[31:0], rxd} : shift_q;
    wcnt_d       = wcnt_q;
    vdin_d       = vdin_q;
    vline_d      = vline_q;
    adin_d       = adin_q;
    v_wr_en_d    = 1'b0;
    a_wr_en_d    = 1'b0;
    line_start_d = 1'b0;
    frame_drop_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bcnt_d = '0;
        if (rx_dv && rxd == PREAMBLE) state_d = ST_PRE;
      end
      ST_DROP: begin
        if (!rx_dv) state_d = ST_IDLE;
      end
      default: begin
        if (!rx_dv) begin
          // Falling rx_dv before TAIL means the frame was cut short.
          state_d      = ST_IDLE;
          frame_drop_d = (state_q != ST_TAIL);
        end else if (rx_er) begin
          state_d      = ST_DROP;
          frame_drop_d = 1'b1;
        end else begin
          case (state_q)
            ST_PRE: begin
              if (rxd == SFD) begin
                state_d  = ST_DST;
                bcnt_d   = '0;
                mac_ok_d = 1'b1;
                bc_ok_d  = 1'b1;
              end else if (rxd != PREAMBLE) begin
                state_d      = ST_DROP;
                frame_drop_d = 1'b1;
              end
            end
            ST_DST: begin
              mac_ok_d = dst_hit;
              bc_ok_d  = bc_hit;
              bcnt_d   = bcnt_q + 3'd1;
              if (bcnt_last) begin
                bcnt_d = '0;
                if (dst_hit || bc_hit) begin
                  state_d = ST_SRC;
                end else begin
                  state_d      = ST_DROP;
                  frame_drop_d = 1'b1;
                end
              end
            end
            ST_SRC: begin
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_last) begin
                bcnt_d  = '0;
                state_d = ST_ETYPE;
              end
            end
            ST_ETYPE: begin
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_q[0]) begin
                bcnt_d = '0;
                if ({shift_q[7:0], rxd} == ETHERTYPE) begin
                  state_d = ST_HDR;
                end else begin
                  state_d      = ST_DROP;
                  frame_drop_d = 1'b1;
                end
              end
            end
            ST_HDR: begin
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_last) begin
                bcnt_d = '0;
                if (hdr_bad) begin
                  state_d      = ST_DROP;
                  frame_drop_d = 1'b1;
                end else begin
                  wcnt_d = cnt_w[10:0];
                  if (is_vid) begin
                    vline_d      = shift_q[18:8];
                    line_start_d = 1'b1;
                    state_d      = ST_VID;
                  end else begin
                    state_d = ST_AUD;
                  end
                end
              end
            end
            ST_VID: begin
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_last) begin
                bcnt_d = '0;
                if (v_full) begin
                  state_d      = ST_DROP;
                  frame_drop_d = 1'b1;
                end else begin
                  vdin_d    = {shift_q, rxd};
                  v_wr_en_d = 1'b1;
                  wcnt_d    = wcnt_q - 11'd1;
                  if (wcnt_q == 11'd1) state_d = ST_TAIL;
                end
              end
            end
            ST_AUD: begin
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_q[0]) begin
                bcnt_d = '0;
                if (a_full) begin
                  state_d      = ST_DROP;
                  frame_drop_d = 1'b1;
                end else begin
                  adin_d    = {shift_q[3:0], rxd};
                  a_wr_en_d = 1'b1;
                  wcnt_d    = wcnt_q - 11'd1;
                  if (wcnt_q == 11'd1) state_d = ST_TAIL;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= '0;
      mac_ok_q     <= 1'b0;
      bc_ok_q      <= 1'b0;
      shift_q      <= '0;
      wcnt_q       <= '0;
      vdin_q       <= '0;
      v_wr_en_q    <= 1'b0;
      vline_q      <= '0;
      line_start_q <= 1'b0;
      adin_q       <= '0;
      a_wr_en_q    <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      mac_ok_q     <= mac_ok_d;
      bc_ok_q      <= bc_ok_d;
      shift_q      <= shift_d;
      wcnt_q       <= wcnt_d;
      vdin_q       <= vdin_d;
      v_wr_en_q    <= v_wr_en_d;
      vline_q      <= vline_d;
      line_start_q <= line_start_d;
      adin_q       <= adin_d;
      a_wr_en_q    <= a_wr_en_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign vdin       = vdin_q;
  assign v_wr_en    = v_wr_en_q;
  assign vline      = vline_q;
  assign line_start = line_start_q;
  assign adin       = adin_q;
  assign a_wr_en    = a_wr_en_q;
  assign frame_drop = frame_drop_q;

`ifdef GMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_nxt;
  logic        frame_err_q, frame_err_d;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (rxd),
    .crc_o  (crc_nxt)
  );

  // CRC covers DST through the FCS; only frames that completed their payload are judged.
  always_comb begin
    crc_d       = crc_q;
    frame_err_d = 1'b0;
    if (state_q == ST_PRE && rx_dv && rxd == SFD) begin
      crc_d = CRC_INIT;
    end else if (rx_dv && (state_q inside {ST_DST, ST_SRC, ST_ETYPE, ST_HDR,
                                           ST_VID, ST_AUD, ST_TAIL})) begin
      crc_d = crc_nxt;
    end
    if (state_q == ST_TAIL && !rx_dv && crc_q != CRC_RESIDUE) frame_err_d = 1'b1;
  end

  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      crc_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
